// File: rtl/chain_pkg.sv
// Shared types for the chain router: lane state encoding and mode constants.
package chain_pkg;

   typedef enum logic [1:0] {
      LANE_IDLE   = 2'd0,
      LANE_STREAM = 2'd1,
      LANE_DONE   = 2'd2
   } lane_state_e;

   localparam logic MODE_STATIC  = 1'b0;
   localparam logic MODE_DYNAMIC = 1'b1;

endpackage

// File: rtl/chain_lane_fifo.sv
// One-bit-wide first-word-fall-through FIFO used as the buffer of one output lane.
module chain_lane_fifo #(
   parameter int FIFO_DEPTH = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic push_i,
   input  logic din_i,
   input  logic pop_i,
   output logic dout_o,
   output logic full_o,
   output logic empty_o
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);

   logic [FIFO_DEPTH-1:0] mem_q;
   logic [PTR_W-1:0]      wr_q;
   logic [PTR_W-1:0]      rd_q;
   logic [PTR_W:0]        cnt_q;
   logic                  do_push;
   logic                  do_pop;

   assign full_o  = (cnt_q == (PTR_W+1)'(FIFO_DEPTH));
   assign empty_o = (cnt_q == '0);
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   assign dout_o  = empty_o ? 1'b0 : mem_q[rd_q];

   // NOTE: storage is deliberately not reset; empty_o masks stale contents, so only pointers need it.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q] <= din_i;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + 1'b1;
         if (do_pop)  rd_q <= rd_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

endmodule

// File: rtl/chain_router.sv
// Routes serial capture chains onto buffered output lanes with static or
// round-robin dynamic assignment, per-lane popped-bit counts and completion flags.
module chain_router
   import chain_pkg::*;
#(
   parameter int CHAINS_IN  = 5,
   parameter int CHAINS_OUT = 3,
   parameter int FIFO_DEPTH = 4,
   parameter int CNT_W      = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        mode,
   input  logic [CHAINS_IN-1:0]        cin_status,
   input  logic [CHAINS_IN-1:0]        cin,
   output logic [CHAINS_IN-1:0]        cin_en,
   input  logic [CHAINS_OUT-1:0]       cout_en,
   output logic [CHAINS_OUT-1:0]       cout,
   output logic [CHAINS_OUT-1:0]       cout_valid,
   output logic [CHAINS_OUT-1:0]       cout_status,
   output logic [CHAINS_OUT*CNT_W-1:0] lane_bits,
   output logic                        all_done
);

   localparam int CIDX_W = (CHAINS_IN > 1) ? $clog2(CHAINS_IN) : 1;

   lane_state_e          state_q [CHAINS_OUT];
   lane_state_e          state_d [CHAINS_OUT];
   logic [CIDX_W-1:0]    chan_q  [CHAINS_OUT];
   logic [CIDX_W-1:0]    chan_d  [CHAINS_OUT];
   logic [CNT_W-1:0]     bits_q  [CHAINS_OUT];
   logic [CNT_W-1:0]     bits_d  [CHAINS_OUT];
   logic [CHAINS_IN-1:0] claimed_q;
   logic [CHAINS_IN-1:0] claimed_d;
   logic [CIDX_W-1:0]    rr_q;
   logic [CIDX_W-1:0]    rr_d;
   logic                 mode_q;

   logic [CHAINS_OUT-1:0] fifo_full;
   logic [CHAINS_OUT-1:0] fifo_empty;
   logic [CHAINS_OUT-1:0] lane_push;
   logic [CHAINS_OUT-1:0] lane_pop;
   logic [CHAINS_OUT-1:0] lane_din;

   // Lanes are visited in ascending order against a shrinking availability mask,
   // so lanes going idle together each receive a distinct chain in one cycle.
   always_comb begin
      logic [CHAINS_IN-1:0] avail;
      logic [CIDX_W-1:0]    pick;
      logic [CIDX_W-1:0]    ptr;
      logic                 found;
      int                   idx;

      // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
      state_d   = state_q;
      chan_d    = chan_q;
      claimed_d = claimed_q;
      cin_en    = '0;
      lane_push = '0;
      avail     = ~claimed_q;
      ptr       = rr_q;
      pick      = '0;
      found     = 1'b0;
      idx       = 0;

      for (int j = 0; j < CHAINS_OUT; j++) begin
         found = 1'b0;
         pick  = '0;
         case (state_q[j])
            LANE_IDLE: begin
               if (mode_q == MODE_STATIC) begin
                  for (int c = CHAINS_IN - 1; c >= 0; c--) begin
                     if ((c % CHAINS_OUT) == j && avail[c]) begin
                        found = 1'b1;
                        pick  = CIDX_W'(c);
                     end
                  end
               end else begin
                  for (int k = CHAINS_IN - 1; k >= 0; k--) begin
                     idx = (int'(ptr) + k) % CHAINS_IN;
                     if (avail[idx]) begin
                        found = 1'b1;
                        pick  = CIDX_W'(idx);
                     end
                  end
               end
               if (found) begin
                  state_d[j]      = LANE_STREAM;
                  chan_d[j]       = pick;
                  avail[pick]     = 1'b0;
                  claimed_d[pick] = 1'b1;
                  if (mode_q == MODE_DYNAMIC) ptr = CIDX_W'((int'(pick) + 1) % CHAINS_IN);
               end else if (fifo_empty[j]) begin
                  state_d[j] = LANE_DONE;
               end
            end
            LANE_STREAM: begin
               if (cin_status[chan_q[j]]) begin
                  state_d[j] = LANE_IDLE;
               end else begin
                  cin_en[chan_q[j]] = !fifo_full[j];
                  lane_push[j]      = !fifo_full[j];
               end
            end
            default: ;
         endcase
      end
      rr_d = ptr;
   end

   always_comb begin
      for (int j = 0; j < CHAINS_OUT; j++) begin
         lane_pop[j] = cout_en[j] && !fifo_empty[j];
         lane_din[j] = cin[chan_q[j]];
         bits_d[j]   = (lane_pop[j] && (bits_q[j] != '1)) ? bits_q[j] + 1'b1 : bits_q[j];
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         mode_q    <= mode;
         claimed_q <= '0;
         rr_q      <= '0;
         for (int j = 0; j < CHAINS_OUT; j++) begin
            state_q[j] <= LANE_IDLE;
            chan_q[j]  <= '0;
            bits_q[j]  <= '0;
         end
      end else begin
         claimed_q <= claimed_d;
         rr_q      <= rr_d;
         state_q   <= state_d;
         chan_q    <= chan_d;
         bits_q    <= bits_d;
      end
   end

   for (genvar j = 0; j < CHAINS_OUT; j++) begin : g_lane
      chain_lane_fifo #(
         .FIFO_DEPTH(FIFO_DEPTH)
      ) u_fifo (
         .clk    (clk),
         .rst    (rst),
         .push_i (lane_push[j]),
         .din_i  (lane_din[j]),
         .pop_i  (lane_pop[j]),
         .dout_o (cout[j]),
         .full_o (fifo_full[j]),
         .empty_o(fifo_empty[j])
      );

      assign cout_valid[j]                = !fifo_empty[j];
      assign cout_status[j]               = (state_q[j] == LANE_DONE);
      assign lane_bits[j*CNT_W +: CNT_W]  = bits_q[j];
   end

   assign all_done = &cout_status;

endmodule

// File: doc/chain_router.md
# chain_router

Parametrised successor to the scan-chain controller in ShadowCapture. It routes CHAINS_IN serial capture chains onto CHAINS_OUT output lanes, with a bit FIFO on each lane. Assignment is either static (fixed chain-to-lane map) or dynamic (any lane that goes idle claims the next unfinished chain in round-robin order). Each lane keeps a bit count, and the block reports per-lane and global completion. It sits between the shadow-capture chains and the downstream serialiser.

## Interface
Parameters:
- CHAINS_IN, 5, number of input chains (≥1)
- CHAINS_OUT, 3, number of output lanes (≥1)
- FIFO_DEPTH, 4, bits buffered per lane; power of two, ≥2
- CNT_W, 16, width of the per-lane popped-bit counter

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- mode  in  1  0 = static, 1 = dynamic; captured on the last cycle rst is high, ignored otherwise
- cin_status  in  CHAINS_IN  1 = chain i exhausted (level, sticky from source)
- cin  in  CHAINS_IN  serial data of chain i
- cin_en  out  CHAINS_IN  shift-enable to chain i; bit is taken on an edge where cin_en[i]=1
- cout_en  in  CHAINS_OUT  downstream ready for lane j
- cout  out  CHAINS_OUT  head bit of lane j FIFO
- cout_valid  out  CHAINS_OUT  lane j FIFO non-empty
- cout_status  out  CHAINS_OUT  lane j finished: no chain left for it and FIFO empty
- lane_bits  out  CHAINS_OUT*CNT_W  lane j popped-bit count, bits [j*CNT_W +: CNT_W]
- all_done  out  1  AND of cout_status

## Operation
- Per-chain claimed flag: set when the chain is granted; cleared only by rst. No chain is ever granted twice.
- Lane FSM states: IDLE, STREAM, DONE.
- IDLE behaviour:
  - The lane takes the next eligible unclaimed chain and goes to STREAM, recording chain index c.
  - If no chain is eligible and the FIFO is empty, it goes to DONE.
  - If no chain is eligible and the FIFO is not empty, it stays in IDLE.
- Eligibility, static mode: lane j owns chains j, j+CHAINS_OUT, j+2·CHAINS_OUT, … and takes them in ascending order.
- Eligibility, dynamic mode:
  - A global round-robin pointer selects the first unclaimed chain at or after the pointer, wrapping at CHAINS_IN.
  - When several lanes are IDLE in the same cycle, they are served in ascending lane index, each receiving a distinct chain in the same cycle.
  - After granting, the pointer moves to the last granted chain + 1, mod CHAINS_IN.
- STREAM behaviour:
  - cin_en[c] = !fifo_full[j] && !cin_status[c]. This is combinational from state, the FIFO full flag and cin_status.
  - On each edge with cin_en[c]=1, cin[c] is pushed.
  - On an edge where cin_status[c]=1, nothing is pushed and the lane goes to IDLE.
- cin_en is 0 for every chain not currently held in STREAM.
- DONE is terminal until rst.
- FIFO:
  - First-word fall-through: cout = head bit, cout_valid = !empty.
  - Pop on an edge with cout_en[j] && cout_valid[j].
  - The push is gated by full only. A pop in the same cycle does not free a slot for a push.
  - Simultaneous push and pop when not full and not empty leaves the occupancy unchanged.
- lane_bits[j] increments on every pop and saturates at 2^CNT_W−1.
- Reset values: cin_en=0, cout=0, cout_valid=0, cout_status=0, lane_bits=0, all_done=0. All FSMs go to IDLE, FIFOs empty, claim flags clear, RR pointer = 0.
- Reset mid-operation discards buffered bits and all claims. The source chains are not rewound.

## Timing
- Grant latency: a lane in IDLE at edge t is in STREAM after t; cin_en can be high in the cycle after edge t.
- Data latency:
  - A bit pushed at edge t is visible on cout/cout_valid right after t (same cycle as the push completes).
  - It is popped at the earliest at edge t+1.
- A zero-length chain (cin_status already 1 at grant) costs 2 cycles: IDLE→STREAM→IDLE, with no push.
- Full FIFO: cin_en drops in the cycle after the push that fills the FIFO. It rises again in the cycle after the first pop.
- Static mode with a lane that owns no chains (j ≥ CHAINS_IN): that lane's cout_status rises in the first cycle after rst deasserts (one IDLE cycle).
- all_done is combinational from the registered cout_status; it has no extra register stage.

## Structure
- Package chain_pkg holds:
  - the lane state encoding (IDLE/STREAM/DONE)
  - the mode constants MODE_STATIC=0 and MODE_DYNAMIC=1
- Shared CHAINS_IN/CHAINS_OUT defaults are taken from the ShadowCapture parameter set; chain_pkg does not carry them.
- The sub-module chain_lane_fifo (bit FIFO, FIFO_DEPTH, full/empty, push/pop) is instantiated once per lane.
- The grant arbiter and the chain→lane cin_en mux stay in chain_router.

## Test plan
- **Static, 5→3, FIFO_DEPTH=4, cout_en=111.**
  - Stimulus: chains 0..4 stream 3 bits each (patterns 101, 011, 110, 001, 111), then cin_status goes high.
  - Required: lane0 outputs 101 then 001; lane1 outputs 011 then 111; lane2 outputs 110.
  - Required: lane_bits = 6, 6, 3; all_done=1 after the last pop.
- **Backpressure.**
  - Stimulus: cout_en[0]=0 for 10 cycles while chain 0 streams.
  - Required: lane0 holds 4 bits and cin_en[0]=0 from the cycle after the 4th push.
  - Required: after cout_en[0]=1, cin_en[0]=1 again one cycle after the first pop; bit order is preserved.
- **Dynamic mode.**
  - Stimulus: chain 1 has 8 bits, all other chains have 1 bit.
  - Required: at the first grant, lanes 0/1/2 receive chains 0/1/2; the RR pointer becomes 3.
  - Required: lane0 finishes first and takes chain 3, lane2 takes chain 4; lane1 alone carries chain 1.
- **Zero-length and surplus lanes.**
  - Stimulus: CHAINS_IN=2, CHAINS_OUT=3, static mode, cin_status=11 from reset.
  - Required: no cin_en pulses at all.
  - Required: lane2 reaches cout_status=1 one cycle after reset; lanes 0/1 reach it 3 cycles after reset (the extra cycles are the STREAM→IDLE of the zero-length chain plus the final IDLE→DONE).
- **Reset mid-stream.**
  - Stimulus: assert rst while lane0 holds 2 bits.
  - Required: the next cycle shows cout_valid=0, lane_bits=0 and cin_en=0.
  - Required: after rst deasserts, the first grant goes back to chain 0.
- **Counter saturation.**
  - Stimulus: CNT_W=3, stream 10 bits through one lane.
  - Required: lane_bits holds at 7.
